// File: rtl/sc_output_collector.sv
// Packs converted results into output rows and writes them out over a valid/ready port.
// Two row buffers alternate so collection can continue while a write is stalled.
module sc_output_collector #(
    parameter int BATCH_SIZE       = 4,
    parameter int OUTPUT_FEATURES  = 4,
    parameter int BINARY_PRECISION = 8,
    parameter int ADDR_WIDTH       = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h4000_0000,
    parameter int ROW_STRIDE       = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [BINARY_PRECISION-1:0]               in_data,
    input  logic                                      in_valid,
    output logic [BINARY_PRECISION*OUTPUT_FEATURES-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0]                     wr_addr,
    output logic                                      wr_valid,
    input  logic                                      wr_ready,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      overflow
);

    localparam int ROW_W = BINARY_PRECISION * OUTPUT_FEATURES;
    localparam int CNT_W = $clog2(BATCH_SIZE + 1);
    localparam int COL_W = (OUTPUT_FEATURES > 1) ? $clog2(OUTPUT_FEATURES) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUTPUT_FEATURES - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(BATCH_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ROW_W-1:0] row_buf [2];
    logic             fill_ptr;
    logic             drain_ptr;
    logic [COL_W-1:0] col;
    logic [CNT_W-1:0] rows_filled;
    logic [CNT_W-1:0] rows_written;
    logic [1:0]       full_count;
    logic [1:0]       full_count_next;

    logic transfer;
    logic accept;
    logic row_done;
    logic last_filled;
    logic last_sent;
    logic drop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // start outranks every other event; an element arriving alongside it is discarded
    always_comb begin
        state_next      = state;
        transfer        = wr_valid && wr_ready;
        accept          = (state == COLLECT) && in_valid && !start &&
                          ((full_count < 2'd2) || transfer);
        row_done        = accept && (col == LAST_COL);
        last_filled     = row_done && (rows_filled == LAST_ROW);
        last_sent       = transfer && (state == DRAIN) && (rows_written == LAST_ROW);
        drop            = in_valid && !start &&
                          (((state == COLLECT) && !accept) || (state == DRAIN));
        full_count_next = full_count + {1'b0, row_done} - {1'b0, transfer};
        busy            = (state != IDLE);

        case (state)
            COLLECT: if (last_filled) state_next = DRAIN;
            DRAIN:   if (last_sent)   state_next = IDLE;
            default: state_next = state;
        endcase

        if (start) begin
            state_next = COLLECT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || start) begin
            row_buf[0]   <= '0;
            row_buf[1]   <= '0;
            fill_ptr     <= 1'b0;
            drain_ptr    <= 1'b0;
            col          <= '0;
            rows_filled  <= '0;
            rows_written <= '0;
            full_count   <= 2'd0;
            wr_valid     <= 1'b0;
            wr_addr      <= BASE_ADDR;
            done         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            // with both buffers full, an accepted element lands in the buffer being drained this edge
            if (accept) begin
                row_buf[fill_ptr][int'(col)*BINARY_PRECISION +: BINARY_PRECISION] <= in_data;
            end

            if (row_done) begin
                fill_ptr    <= ~fill_ptr;
                col         <= '0;
                rows_filled <= rows_filled + 1'b1;
            end else if (accept) begin
                col <= col + 1'b1;
            end

            if (transfer) begin
                drain_ptr    <= ~drain_ptr;
                rows_written <= rows_written + 1'b1;
                wr_addr      <= wr_addr + ADDR_WIDTH'(ROW_STRIDE);
            end

            full_count <= full_count_next;
            wr_valid   <= (full_count_next != 2'd0);

            if (last_sent) begin
                done <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign wr_data = row_buf[drain_ptr];

endmodule
